// File: rtl/fan_adder_tree.sv
// fan_adder_tree: forwarding adder network that reduces N lane products into
// contiguous, variable-size reduction groups in a single registered pass.
// Adder i sits between lanes i and i+1 (in-order indexing). Its level is the
// number of trailing ones of i. Its operands are chosen from the leaf lane or
// from lower-level adders on the facing boundary of each span.
// Optional feature: define FAN_SAT_EN to make every adder sum saturate to
// 2^DW_DATA-1 instead of wrapping.
module fan_adder_tree #(
  parameter int DW_DATA = 8,
  parameter int N       = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N-2:0]                   add_en,
  input  logic [N-2:0]                   bypass_en,
  input  logic [6*(N-1)-1:0]             sel,
  input  logic [DW_DATA*N-1:0]           in,
  input  logic [2*N-1:0]                 edge_tag_in,
  output logic [2*(N-1)-1:0]             out_valid,
  output logic [DW_DATA*2*(N-1)-1:0]     out
);

  localparam int N_ADDERS = N - 1;
  // Operand word: {end tag, start tag, value}
  localparam int OPW = DW_DATA + 2;

  function automatic int trailing_ones(input int v);
    int   c;
    logic run;
    c   = 0;
    run = 1'b1;
    for (int b = 0; b < 31; b++) begin
      if (run && v[b]) begin
        c++;
      end else begin
        run = 1'b0;
      end
    end
    return c;
  endfunction

  logic [DW_DATA*2*N_ADDERS-1:0] out_d;
  logic [2*N_ADDERS-1:0]         valid_d;

  for (genvar i = 0; i < N_ADDERS; i++) begin : g_adder
    localparam int LVL = trailing_ones(i);

    // Candidate tables are indexed directly by the 3-bit select; entries
    // beyond this adder's level stay zero with a cleared tag.
    logic [OPW-1:0]     cl [8];
    logic [OPW-1:0]     cr [8];
    logic [2:0]         sel_l;
    logic [2:0]         sel_r;
    logic [OPW-1:0]     l_op;
    logic [OPW-1:0]     r_op;
    logic [DW_DATA-1:0] sum;
    logic [OPW-1:0]     fwd_l;
    logic [OPW-1:0]     fwd_r;
    logic [DW_DATA-1:0] slot_a;
    logic [DW_DATA-1:0] slot_b;
    logic               valid_a;
    logic               valid_b;
    logic               unused_fwd;

    assign sel_l = sel[6*i +: 3];
    assign sel_r = sel[6*i+3 +: 3];

    assign cl[0] = {edge_tag_in[2*i +: 2], in[DW_DATA*i +: DW_DATA]};
    assign cr[0] = {edge_tag_in[2*(i+1) +: 2], in[DW_DATA*(i+1) +: DW_DATA]};

    for (genvar k = 1; k < 8; k++) begin : g_cand
      if (k <= LVL) begin : g_link
        assign cl[k] = g_adder[i - (1 << (k - 1))].fwd_r;
        assign cr[k] = g_adder[i + (1 << (k - 1))].fwd_l;
      end else begin : g_none
        assign cl[k] = '0;
        assign cr[k] = '0;
      end
    end

    assign l_op = cl[sel_l];
    assign r_op = cr[sel_r];

`ifdef FAN_SAT_EN
    logic [DW_DATA:0] wide_sum;
    assign wide_sum = {1'b0, l_op[DW_DATA-1:0]} + {1'b0, r_op[DW_DATA-1:0]};
    assign sum      = wide_sum[DW_DATA] ? '1 : wide_sum[DW_DATA-1:0];
`else
    assign sum = l_op[DW_DATA-1:0] + r_op[DW_DATA-1:0];
`endif

    // Per-adder function: sum (add has priority), bypass, or idle
    always_comb begin
      fwd_l   = '0;
      fwd_r   = '0;
      slot_a  = '0;
      slot_b  = '0;
      valid_a = 1'b0;
      valid_b = 1'b0;
      if (add_en[i]) begin
        fwd_l   = {r_op[DW_DATA+1], l_op[DW_DATA], sum};
        fwd_r   = {r_op[DW_DATA+1], l_op[DW_DATA], sum};
        slot_a  = sum;
        valid_a = l_op[DW_DATA] & r_op[DW_DATA+1];
      end else if (bypass_en[i]) begin
        fwd_l   = l_op;
        fwd_r   = r_op;
        slot_a  = l_op[DW_DATA-1:0];
        valid_a = l_op[DW_DATA] & l_op[DW_DATA+1];
        slot_b  = r_op[DW_DATA-1:0];
        valid_b = r_op[DW_DATA] & r_op[DW_DATA+1];
      end
    end

    assign out_d[DW_DATA*(2*i) +: DW_DATA]   = slot_a;
    assign out_d[DW_DATA*(2*i+1) +: DW_DATA] = slot_b;
    assign valid_d[2*i]                      = valid_a;
    assign valid_d[2*i+1]                    = valid_b;

    // The root's forwards (and some boundary forwards) have no consumer
    assign unused_fwd = ^{fwd_l, fwd_r};
  end

  // Output register; reset clears results immediately and drops any in-flight data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= '0;
    end else begin
      out       <= out_d;
      out_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_fan_adder_tree.sv
// tb_fan_adder_tree: directed vectors with hand-computed results, checked by a
// scoreboard queue that a separate monitor drains one cycle after each issue.
module tb_fan_adder_tree;

  localparam int DW = 8;
  localparam int N  = 32;
  localparam int NA = N - 1;
  localparam int OW = DW * 2 * NA;
  localparam int VW = 2 * NA;

  logic            clk;
  logic            rst_n;
  logic [NA-1:0]   add_en;
  logic [NA-1:0]   bypass_en;
  logic [6*NA-1:0] sel;
  logic [DW*N-1:0] in_data;
  logic [2*N-1:0]  edge_tag;
  logic [VW-1:0]   out_valid;
  logic [OW-1:0]   out;

  int n_checks;
  int n_fail;

  string         name_q[$];
  logic [OW-1:0] out_q[$];
  logic [OW-1:0] mask_q[$];
  logic [VW-1:0] valid_q[$];

  logic [OW-1:0] exp_out;
  logic [OW-1:0] exp_mask;
  logic [VW-1:0] exp_valid;

  fan_adder_tree #(.DW_DATA(DW), .N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .add_en     (add_en),
    .bypass_en  (bypass_en),
    .sel        (sel),
    .in         (in_data),
    .edge_tag_in(edge_tag),
    .out_valid  (out_valid),
    .out        (out)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [OW-1:0] act,
                              input logic [OW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic clear_inputs();
    add_en    = '0;
    bypass_en = '0;
    sel       = '0;
    in_data   = '0;
    edge_tag  = '0;
  endtask

  task automatic ramp_lanes();
    for (int j = 0; j < N; j++) in_data[DW*j +: DW] = DW'(j);
  endtask

  task automatic set_sel(input int i, input logic [2:0] l, input logic [2:0] r);
    sel[6*i +: 3]   = l;
    sel[6*i+3 +: 3] = r;
  endtask

  task automatic set_start(input int j);
    edge_tag[2*j] = 1'b1;
  endtask

  task automatic set_end(input int j);
    edge_tag[2*j+1] = 1'b1;
  endtask

  task automatic new_expect(input bit full_mask);
    exp_out   = '0;
    exp_mask  = full_mask ? '1 : '0;
    exp_valid = '0;
  endtask

  task automatic expect_slot(input int s, input logic [DW-1:0] v);
    exp_out[DW*s +: DW]  = v;
    exp_mask[DW*s +: DW] = '1;
  endtask

  task automatic apply_stimulus(input string name);
    name_q.push_back(name);
    out_q.push_back(exp_out);
    mask_q.push_back(exp_mask);
    valid_q.push_back(exp_valid);
    @(posedge clk);
  endtask

  // Monitor: the registered result appears after each rising edge
  always @(posedge clk) begin
    string         nm;
    logic [OW-1:0] eo;
    logic [OW-1:0] em;
    logic [VW-1:0] ev;
    #1;
    if (name_q.size() > 0) begin
      nm = name_q.pop_front();
      eo = out_q.pop_front();
      em = mask_q.pop_front();
      ev = valid_q.pop_front();
      check_output({nm, "_out"}, out & em, eo);
      check_output({nm, "_valid"}, OW'(out_valid), OW'(ev));
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk      = 1'b0;
    rst_n    = 1'b1;

    // Pair-group inputs held through reset so outputs would be nonzero if captured
    clear_inputs();
    ramp_lanes();
    for (int k = 0; k < 16; k++) begin
      add_en[2*k] = 1'b1;
      set_start(2*k);
      set_end(2*k+1);
    end

    #2 rst_n = 1'b0;
    #1;
    check_output("reset_async_out", out, '0);
    check_output("reset_async_valid", OW'(out_valid), '0);
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_hold_out", out, '0);
    check_output("reset_hold_valid", OW'(out_valid), '0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("release_out", out, '0);
    check_output("release_valid", OW'(out_valid), '0);

    // Pair groups: adder 2k sums lanes 2k and 2k+1 = 4k+1
    new_expect(1'b1);
    for (int k = 0; k < 16; k++) begin
      expect_slot(4*k, DW'(4*k + 1));
      exp_valid[4*k] = 1'b1;
    end
    apply_stimulus("pairs");

    // Reset asserted mid-cycle with new data in flight
    @(negedge clk);
    clear_inputs();
    ramp_lanes();
    bypass_en[0] = 1'b1;
    set_start(0); set_end(0); set_start(1); set_end(1);
    #2 rst_n = 1'b0;
    #1;
    check_output("midop_clear_out", out, '0);
    check_output("midop_clear_valid", OW'(out_valid), '0);
    @(posedge clk);
    #1;
    check_output("midop_discard_out", out, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bypass: slot0 = lane0 = 0, slot1 = lane1 = 1, both valid
    @(negedge clk);
    clear_inputs();
    ramp_lanes();
    bypass_en[0] = 1'b1;
    set_start(0); set_end(0); set_start(1); set_end(1);
    new_expect(1'b1);
    expect_slot(0, 8'd0);
    expect_slot(1, 8'd1);
    exp_valid = VW'(2'b11);
    apply_stimulus("bypass");

    // Full reduction of 0..31 = 496 at the root (adder 15, slot 30)
    @(negedge clk);
    clear_inputs();
    ramp_lanes();
    add_en = '1;
    for (int i = 0; i < NA; i++) begin
      int lv;
      lv = 0;
      while (lv < 5 && ((i >> lv) & 1) == 1) lv++;
      set_sel(i, 3'(lv), 3'(lv));
    end
    set_start(0);
    set_end(31);
    new_expect(1'b0);
`ifdef FAN_SAT_EN
    expect_slot(30, 8'd255);
`else
    expect_slot(30, 8'd240);
`endif
    exp_valid[30] = 1'b1;
    apply_stimulus("full_reduce");

    // Forwarding skip: level-1 adder 1 taking leaves 1 and 2 directly
    @(negedge clk);
    clear_inputs();
    ramp_lanes();
    add_en[1] = 1'b1;
    set_start(1);
    set_end(2);
    new_expect(1'b1);
    expect_slot(2, 8'd3);
    exp_valid[2] = 1'b1;
    apply_stimulus("fwd_skip");

    // Out-of-range left select on level-0 adder gives operand 0, tag 0
    @(negedge clk);
    clear_inputs();
    ramp_lanes();
    add_en[0] = 1'b1;
    set_sel(0, 3'd3, 3'd0);
    set_start(0);
    set_end(1);
    new_expect(1'b1);
    expect_slot(0, 8'd1);
    apply_stimulus("sel_oor");

    // Overflow: 200 + 100 wraps to 44 (or saturates to 255)
    @(negedge clk);
    clear_inputs();
    in_data[7:0]  = 8'd200;
    in_data[15:8] = 8'd100;
    add_en[0] = 1'b1;
    set_start(0);
    set_end(1);
    new_expect(1'b1);
`ifdef FAN_SAT_EN
    expect_slot(0, 8'd255);
`else
    expect_slot(0, 8'd44);
`endif
    exp_valid[0] = 1'b1;
    apply_stimulus("overflow");

    // Bypass with partial tags: lane2 start only (invalid), lane3 start+end (valid)
    @(negedge clk);
    clear_inputs();
    in_data[DW*2 +: DW] = 8'd7;
    in_data[DW*3 +: DW] = 8'd9;
    bypass_en[2] = 1'b1;
    set_start(2);
    set_start(3); set_end(3);
    new_expect(1'b1);
    expect_slot(4, 8'd7);
    expect_slot(5, 8'd9);
    exp_valid[5] = 1'b1;
    apply_stimulus("bypass_partial");

    // Right select 1: adder 5 adds lane 5 to adder 6's sum of lanes 6,7 (13) = 18
    @(negedge clk);
    clear_inputs();
    ramp_lanes();
    add_en[5] = 1'b1;
    add_en[6] = 1'b1;
    set_sel(5, 3'd0, 3'd1);
    set_start(5);
    set_end(7);
    new_expect(1'b1);
    expect_slot(10, 8'd18);
    expect_slot(12, 8'd13);
    exp_valid[10] = 1'b1;
    apply_stimulus("right_sel");

    // No enables: everything zero and invalid despite data and tags
    @(negedge clk);
    clear_inputs();
    ramp_lanes();
    edge_tag = '1;
    sel      = '1;
    new_expect(1'b1);
    apply_stimulus("idle");

    // Add priority over bypass, left operand forwarded through a bypassing adder 0
    @(negedge clk);
    clear_inputs();
    ramp_lanes();
    bypass_en[0] = 1'b1;
    add_en[1]    = 1'b1;
    bypass_en[1] = 1'b1;
    set_sel(1, 3'd1, 3'd0);
    set_start(1);
    set_end(2);
    new_expect(1'b1);
    expect_slot(1, 8'd1);
    expect_slot(2, 8'd3);
    exp_valid[2] = 1'b1;
    apply_stimulus("chain_priority");

    @(negedge clk);
    clear_inputs();
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (name_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending required 0", name_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
